updown_decoder: RTL and testbench
=================================

# updown_decoder

Observer that samples the 4-bit value produced by the team's up/down counter and reconstructs the command that produced each step: hold, count up, count down, or parallel load (jump). It also tracks direction, detects wrap-around and reversals, and keeps a saturating run length of same-direction steps. It sits on the monitor/consumer side of the counter and feeds status logic and testbench scoreboards.

## Interface
- `WIDTH`, 4, counter value width; must be ≥ 2.
- `RUN_W`, 8, run-length counter width.

- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `valid` input 1: `cnt` holds a new counter sample this cycle.
- `resync` input 1: synchronous; discards the baseline and returns to IDLE.
- `cnt` input WIDTH: sampled counter value.
- `cmd_valid` output 1: `cmd` and the pulse outputs are meaningful this cycle.
- `cmd` output 2: decoded step; HOLD=0, UP=1, DOWN=2, JUMP=3.
- `jump_data` output WIDTH: loaded value, updated on JUMP only.
- `dir` output 2: direction state; STILL=0, UP=1, DOWN=2, IDLE=3.
- `wrap_up` output 1: pulse on an UP step from all-ones to 0.
- `wrap_down` output 1: pulse on a DOWN step from 0 to all-ones.
- `reversal` output 1: pulse on a direct UP↔DOWN direction change.
- `run_len` output RUN_W: consecutive steps in the current direction; saturates.

## Operation
- `prev` is a WIDTH register holding the last accepted sample.
- Direction state machine: IDLE, STILL, UP, DOWN.
- Reset values:
  - `dir` = IDLE.
  - `prev`, `jump_data`, `cmd`, `run_len` = 0.
  - `cmd_valid`, `wrap_up`, `wrap_down`, `reversal` = 0.
- IDLE with `valid`: load `prev` from `cnt`, move to STILL, keep `cmd_valid` = 0.
- Other states with `valid`: compute `delta = cnt - prev` mod 2^WIDTH.
  - `delta` = 0: HOLD.
  - `delta` = 1: UP.
  - `delta` = all-ones: DOWN.
  - Any other `delta`: JUMP.
  - Then `prev` ← `cnt` and `cmd_valid` = 1.
- State transitions on a decoded step:
  - HOLD: no state change.
  - UP: go to UP.
  - DOWN: go to DOWN.
  - JUMP: go to STILL; `jump_data` ← `cnt`.
- `reversal` = 1 when the state moves UP→DOWN or DOWN→UP on the step itself. STILL→UP or STILL→DOWN is not a reversal.
- `wrap_up` = UP and `prev` = all-ones. `wrap_down` = DOWN and `prev` = 0.
- `run_len` update rules:
  - UP or DOWN in the same direction as `dir`: increment, saturating at 2^RUN_W-1.
  - UP or DOWN in a new direction (from STILL, or a reversal): set to 1.
  - JUMP: set to 0.
  - HOLD: unchanged.
- `valid` = 0: no state change; `cmd_valid` and all pulses = 0; `cmd`, `jump_data`, `run_len` hold their values.
- `resync` = 1: go to IDLE, `run_len` ← 0, `cmd_valid` and pulses = 0.
  - If `valid` is also 1, that sample becomes the new baseline: `prev` ← `cnt`, then STILL.
  - `resync` takes priority over decoding.

## Timing
- All outputs are registered.
- A sample accepted at edge N is reported at the outputs after edge N; latency is 1 cycle.
- Pulses are high for exactly one cycle per accepted sample.
- Back-to-back `valid` is supported at full rate with no stalls.
- `rst` asserted mid-stream clears everything immediately, asynchronously. The first `valid` after `rst` deasserts is treated as a baseline only.
- WIDTH = 2 edge case: `delta` = 2 decodes as JUMP.

## Structure
- Shared package `updown_pkg` holds:
  - The `cmd` encoding constants: HOLD, UP, DOWN, JUMP.
  - The `dir` state encoding: STILL, UP, DOWN, IDLE.
  - Both are shared with the counter's bench and its status logic.
- One natural sub-module, `step_classify`: combinational; maps `prev` and `cnt` to `cmd`, `wrap_up`, `wrap_down`.
- The FSM and `run_len` stay in the top module.

## Test plan
- Reset, then samples 5, 6, 7 → first sample gives no `cmd_valid`; then UP, UP; `dir` = UP, `run_len` = 2.
- Samples 14, 15, 0 → UP, UP with `wrap_up` on the 15→0 step; then samples 0, 15 → HOLD, DOWN with `wrap_down` and `reversal`; `run_len` = 1.
- Samples 3, 9 → JUMP, `jump_data` = 9, `dir` = STILL, `run_len` = 0; a following sample 9 → HOLD with `run_len` still 0.
- 300 consecutive UP steps with RUN_W = 8 → `run_len` saturates at 255.
- `valid` gaps between samples 4 and 5 → UP reported once; `cmd_valid` low during the gaps.
- `resync` with `valid` at sample 8, then sample 2 → no output for 8; then JUMP, `jump_data` = 2.
- `rst` pulsed mid-run → all outputs return to reset values, `dir` = IDLE.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared encodings for the up/down counter family:
// decoded step commands and direction states.
package updown_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2,
        CMD_JUMP = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        DIR_STILL = 2'd0,
        DIR_UP    = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_IDLE  = 2'd3
    } dir_e;

endpackage

// File: rtl/step_classify.sv
// Combinational step classifier: compares the previous and current
// counter samples and names the command that produced the step.
module step_classify
    import updown_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic [WIDTH-1:0] i_cnt,
    output cmd_e             o_cmd,
    output logic             o_wrap_up,
    output logic             o_wrap_down
);

    logic [WIDTH-1:0] w_delta;

    // Modular difference makes wrap-around steps look like +1 / -1.
    assign w_delta = i_cnt - i_prev;

    always_comb begin
        o_cmd = CMD_JUMP;
        unique case (1'b1)
            (w_delta == '0):          o_cmd = CMD_HOLD;
            (w_delta == WIDTH'(1)):   o_cmd = CMD_UP;
            (w_delta == {WIDTH{1'b1}}): o_cmd = CMD_DOWN;
            default:                  o_cmd = CMD_JUMP;
        endcase
    end

    assign o_wrap_up   = (o_cmd == CMD_UP)   && (i_prev == {WIDTH{1'b1}});
    assign o_wrap_down = (o_cmd == CMD_DOWN) && (i_prev == '0);

endmodule

// File: rtl/updown_decoder.sv
// Reconstructs counter commands from sampled values and tracks
// direction, wraps, reversals and a saturating run length.
module updown_decoder
    import updown_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             resync,
    input  logic [WIDTH-1:0] cnt,
    output logic             cmd_valid,
    output logic [1:0]       cmd,
    output logic [WIDTH-1:0] jump_data,
    output logic [1:0]       dir,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             reversal,
    output logic [RUN_W-1:0] run_len
);

    dir_e             r_dir;
    cmd_e             r_cmd;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_jump;
    logic [RUN_W-1:0] r_run;
    logic             r_cv;
    logic             r_wu;
    logic             r_wd;
    logic             r_rev;

    dir_e             w_dir_nxt;
    cmd_e             w_cmd_nxt;
    logic [WIDTH-1:0] w_prev_nxt;
    logic [WIDTH-1:0] w_jump_nxt;
    logic [RUN_W-1:0] w_run_nxt;
    logic [RUN_W-1:0] w_run_inc;
    logic             w_cv_nxt;
    logic             w_wu_nxt;
    logic             w_wd_nxt;
    logic             w_rev_nxt;

    cmd_e             w_cmd;
    logic             w_wu;
    logic             w_wd;

    step_classify #(
        .WIDTH (WIDTH)
    ) u_step_classify (
        .i_prev      (r_prev),
        .i_cnt       (cnt),
        .o_cmd       (w_cmd),
        .o_wrap_up   (w_wu),
        .o_wrap_down (w_wd)
    );

    assign w_run_inc = (r_run == {RUN_W{1'b1}}) ? r_run
                                                : r_run + RUN_W'(1);

    always_comb begin
        w_dir_nxt  = r_dir;
        w_cmd_nxt  = r_cmd;
        w_prev_nxt = r_prev;
        w_jump_nxt = r_jump;
        w_run_nxt  = r_run;
        w_cv_nxt   = 1'b0;
        w_wu_nxt   = 1'b0;
        w_wd_nxt   = 1'b0;
        w_rev_nxt  = 1'b0;
        if (resync) begin
            w_run_nxt = '0;
            if (valid) begin
                w_prev_nxt = cnt;
                w_dir_nxt  = DIR_STILL;
            end else begin
                w_dir_nxt  = DIR_IDLE;
            end
        end else if (valid) begin
            w_prev_nxt = cnt;
            if (r_dir == DIR_IDLE) begin
                w_dir_nxt = DIR_STILL;
            end else begin
                w_cv_nxt  = 1'b1;
                w_cmd_nxt = w_cmd;
                w_wu_nxt  = w_wu;
                w_wd_nxt  = w_wd;
                unique case (w_cmd)
                    CMD_UP: begin
                        w_dir_nxt = DIR_UP;
                        w_rev_nxt = (r_dir == DIR_DOWN);
                        w_run_nxt = (r_dir == DIR_UP) ? w_run_inc
                                                      : RUN_W'(1);
                    end
                    CMD_DOWN: begin
                        w_dir_nxt = DIR_DOWN;
                        w_rev_nxt = (r_dir == DIR_UP);
                        w_run_nxt = (r_dir == DIR_DOWN) ? w_run_inc
                                                        : RUN_W'(1);
                    end
                    CMD_JUMP: begin
                        w_dir_nxt  = DIR_STILL;
                        w_jump_nxt = cnt;
                        w_run_nxt  = '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir  <= DIR_IDLE;
            r_cmd  <= CMD_HOLD;
            r_prev <= '0;
            r_jump <= '0;
            r_run  <= '0;
            r_cv   <= 1'b0;
            r_wu   <= 1'b0;
            r_wd   <= 1'b0;
            r_rev  <= 1'b0;
        end else begin
            r_dir  <= w_dir_nxt;
            r_cmd  <= w_cmd_nxt;
            r_prev <= w_prev_nxt;
            r_jump <= w_jump_nxt;
            r_run  <= w_run_nxt;
            r_cv   <= w_cv_nxt;
            r_wu   <= w_wu_nxt;
            r_wd   <= w_wd_nxt;
            r_rev  <= w_rev_nxt;
        end
    end

    assign cmd_valid = r_cv;
    assign cmd       = r_cmd;
    assign jump_data = r_jump;
    assign dir       = r_dir;
    assign wrap_up   = r_wu;
    assign wrap_down = r_wd;
    assign reversal  = r_rev;
    assign run_len   = r_run;

endmodule

// File: tb/tb_updown_decoder.sv
// Scoreboard bench for updown_decoder: stimulus pushes model
// expectations, a negedge monitor pops them when cmd_valid shows.
module tb_updown_decoder;

    localparam int W    = 4;
    localparam int RW   = 8;
    localparam int M    = 1 << W;
    localparam int RMAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid;
    logic          resync;
    logic [W-1:0]  cnt;
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic [W-1:0]  jump_data;
    logic [1:0]    dir;
    logic          wrap_up;
    logic          wrap_down;
    logic          reversal;
    logic [RW-1:0] run_len;

    updown_decoder #(
        .WIDTH (W),
        .RUN_W (RW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .resync    (resync),
        .cnt       (cnt),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .jump_data (jump_data),
        .dir       (dir),
        .wrap_up   (wrap_up),
        .wrap_down (wrap_down),
        .reversal  (reversal),
        .run_len   (run_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cmd;
        int jd;
        int dir;
        bit wu;
        bit wd;
        bit rev;
        int run;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: dir 0=still 1=up 2=down 3=idle
    bit   base;
    int   mprev;
    int   mdir;
    int   mrun;
    int   mjd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (cmd_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_cmd_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("latency", cyc, e.cyc);
                chk("cmd", int'(cmd), e.cmd);
                chk("jump_data", int'(jump_data), e.jd);
                chk("dir", int'(dir), e.dir);
                chk("wrap_up", int'(wrap_up), int'(e.wu));
                chk("wrap_down", int'(wrap_down), int'(e.wd));
                chk("reversal", int'(reversal), int'(e.rev));
                chk("run_len", int'(run_len), e.run);
            end
        end else begin
            chk("pulses_idle", int'({wrap_up, wrap_down, reversal}), 0);
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("missing_cmd_valid", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic model_reset();
        base  = 1'b0;
        mprev = 0;
        mdir  = 3;
        mrun  = 0;
        mjd   = 0;
    endtask

    task automatic send(bit v, bit rs, int c);
        exp_t e;
        int   d;
        valid  = v;
        resync = rs;
        cnt    = c[W-1:0];
        if (rs) begin
            base = v;
            mrun = 0;
            mdir = v ? 0 : 3;
            if (v) mprev = c;
        end else if (v) begin
            if (!base) begin
                base  = 1'b1;
                mprev = c;
                mdir  = 0;
            end else begin
                d = (c - mprev + M) % M;
                if (d == 0)          e.cmd = 0;
                else if (d == 1)     e.cmd = 1;
                else if (d == M - 1) e.cmd = 2;
                else                 e.cmd = 3;
                e.wu  = (e.cmd == 1) && (mprev == M - 1);
                e.wd  = (e.cmd == 2) && (mprev == 0);
                e.rev = (e.cmd == 1 && mdir == 2) ||
                        (e.cmd == 2 && mdir == 1);
                if (e.cmd == 1 || e.cmd == 2) begin
                    if (mdir == e.cmd)
                        mrun = (mrun < RMAX) ? mrun + 1 : RMAX;
                    else
                        mrun = 1;
                    mdir = e.cmd;
                end else if (e.cmd == 3) begin
                    mrun = 0;
                    mdir = 0;
                    mjd  = c;
                end
                mprev = c;
                e.jd  = mjd;
                e.dir = mdir;
                e.run = mrun;
                e.cyc = cyc + 1;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        valid  = 1'b0;
        resync = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_dir"}, int'(dir), 3);
        chk({tag, "_cmd_valid"}, int'(cmd_valid), 0);
        chk({tag, "_cmd"}, int'(cmd), 0);
        chk({tag, "_jump_data"}, int'(jump_data), 0);
        chk({tag, "_run_len"}, int'(run_len), 0);
        chk({tag, "_pulses"},
            int'({wrap_up, wrap_down, reversal}), 0);
    endtask

    initial begin
        rst    = 1'b1;
        valid  = 1'b0;
        resync = 1'b0;
        cnt    = '0;
        model_reset();
        idle(2);
        chk_reset_vals("reset");
        rst = 1'b0;
        idle(1);

        send(1, 0, 5);
        chk("baseline_no_cmd", int'(cmd_valid), 0);
        send(1, 0, 6);
        send(1, 0, 7);
        chk("t1_dir", int'(dir), 1);
        chk("t1_run", int'(run_len), 2);

        send(1, 0, 14);
        send(1, 0, 15);
        send(1, 0, 0);
        chk("t2_wrap_up", int'(wrap_up), 1);
        send(1, 0, 0);
        send(1, 0, 15);
        chk("t2_wrap_down", int'(wrap_down), 1);
        chk("t2_reversal", int'(reversal), 1);
        chk("t2_run", int'(run_len), 1);

        send(1, 0, 3);
        send(1, 0, 9);
        chk("t3_jump_data", int'(jump_data), 9);
        chk("t3_dir", int'(dir), 0);
        chk("t3_run", int'(run_len), 0);
        send(1, 0, 9);
        chk("t3_hold_cmd", int'(cmd), 0);
        chk("t3_hold_run", int'(run_len), 0);

        send(1, 0, 0);
        for (int i = 1; i <= 300; i++) send(1, 0, i % M);
        chk("t4_saturate", int'(run_len), 255);

        send(1, 0, 4);
        idle(3);
        send(1, 0, 5);
        idle(2);
        chk("t5_gap_cv", int'(cmd_valid), 0);

        send(1, 1, 8);
        chk("t6_resync_cv", int'(cmd_valid), 0);
        chk("t6_resync_dir", int'(dir), 0);
        chk("t6_resync_run", int'(run_len), 0);
        send(1, 0, 2);
        chk("t6_jump_cmd", int'(cmd), 3);
        chk("t6_jump_data", int'(jump_data), 2);

        for (int i = 0; i < 400; i++) begin
            int r;
            int c;
            r = $urandom_range(0, 9);
            if (r < 4)      c = (mprev + 1) % M;
            else if (r < 7) c = (mprev + M - 1) % M;
            else if (r < 8) c = mprev;
            else            c = $urandom_range(0, M - 1);
            send($urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, c);
        end

        send(1, 0, mprev);
        send(1, 0, (mprev + 1) % M);
        idle(2);
        rst = 1'b1;
        #3;
        chk_reset_vals("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        q.delete();
        idle(1);
        send(1, 0, 3);
        chk("t7_baseline_cv", int'(cmd_valid), 0);
        send(1, 0, 4);
        chk("t7_up_cmd", int'(cmd), 1);
        chk("t7_up_run", int'(run_len), 1);

        idle(3);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
